// File: rtl/main_pkg.sv
// rtl/main_pkg.sv - shared types and constants for the switch-driven multiplier board block
// Purpose: FSM state type, operand width and active-low seven-segment patterns.
// Segment patterns are active-low with bit0=a .. bit6=g.
package main_pkg;

  localparam int OPERAND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

endpackage

// File: rtl/main_debounce.sv
// rtl/main_debounce.sv - button synchronizer and debouncer with press pulse
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw asynchronous button level
//   level      : accepted (debounced) level
//   press      : one-cycle pulse on an accepted 0->1 change, aligned with level rising
module main_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreeing cycle restarts the stability window.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/main.sv
// rtl/main.sv - signed 8x8 shift-add multiplier with debounced buttons and 7-segment display
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   num1, num2          : two's complement operands from switches
//   *_btn               : raw start / clear / scroll-right / scroll-left buttons
//   segments, anodes    : active-low multiplexed 4-digit display drive
//   done                : product valid
//   *_led               : debounced button levels
//   load, dir, en       : debug strobes (operand load, last scroll direction, iterating)
module main
  import main_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFRESH_BITS    = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] num1,
  input  logic [OPERAND_W-1:0] num2,
  input  logic                 start_btn,
  input  logic                 rst_btn,
  input  logic                 shift_right_btn,
  input  logic                 shift_left_btn,
  output logic [6:0]           segments,
  output logic [3:0]           anodes,
  output logic                 done,
  output logic                 sh_right_led,
  output logic                 sh_left_led,
  output logic                 rst_led,
  output logic                 start_led,
  output logic                 load,
  output logic                 dir,
  output logic                 en
);

  logic start_press, clr_press, right_press, left_press;

  main_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_in(start_btn), .level(start_led), .press(start_press));
  main_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_in(rst_btn), .level(rst_led), .press(clr_press));
  main_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn_in(shift_right_btn), .level(sh_right_led), .press(right_press));
  main_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn_in(shift_left_btn), .level(sh_left_led), .press(left_press));

  // |-128| = 128 still fits in 8 unsigned bits.
  function automatic logic [OPERAND_W-1:0] mag(input logic [OPERAND_W-1:0] v);
    return v[OPERAND_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [19:0] to_bcd(input logic [14:0] bin);
    logic [34:0] sh;
    sh = {20'd0, bin};
    for (int i = 0; i < 15; i++) begin
      for (int d = 0; d < 5; d++) begin
        if (sh[15+4*d +: 4] >= 4'd5) sh[15+4*d +: 4] = sh[15+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[34:15];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] pick(input logic [19:0] bcd, input logic [2:0] pos);
    case (pos)
      3'd0:    return bcd[3:0];
      3'd1:    return bcd[7:4];
      3'd2:    return bcd[11:8];
      3'd3:    return bcd[15:12];
      3'd4:    return bcd[19:16];
      default: return 4'd0;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [OPERAND_W-1:0]    mcand_q, mcand_d, mplier_q, mplier_d;
  logic [14:0]             acc_q, acc_d, acc_next, product_q, product_d;
  logic [2:0]              count_q, count_d;
  logic                    sign_q, sign_d, done_q, done_d, load_q, load_d, en_q, en_d;
  logic                    dir_q, dir_d;
  logic [1:0]              idx_q, idx_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    sign_d    = sign_q;
    done_d    = done_q;
    load_d    = 1'b0;
    en_d      = en_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    refresh_d = refresh_q + 1'b1;
    acc_next  = mplier_q[0] ? acc_q + (15'(mcand_q) << count_q) : acc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_press) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        mcand_d  = mag(num1);
        mplier_d = mag(num2);
        sign_d   = num1[OPERAND_W-1] ^ num2[OPERAND_W-1];
        acc_d    = '0;
        count_d  = '0;
        done_d   = 1'b0;
        en_d     = 1'b1;
        state_d  = ST_RUN;
      end
      default: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == 3'd7) begin
          state_d   = ST_DONE;
          en_d      = 1'b0;
          done_d    = 1'b1;
          product_d = acc_next;
        end
      end
    endcase

    if (left_press && !right_press) begin
      dir_d = 1'b1;
      if (idx_q != 2'd2) idx_d = idx_q + 1'b1;
    end else if (right_press && !left_press) begin
      dir_d = 1'b0;
      if (idx_q != 2'd0) idx_d = idx_q - 1'b1;
    end

    // Clear overrides any start or scroll request in the same cycle.
    if (clr_press) begin
      state_d   = ST_IDLE;
      product_d = '0;
      sign_d    = 1'b0;
      done_d    = 1'b0;
      load_d    = 1'b0;
      en_d      = 1'b0;
      idx_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      idx_q     <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      load_q    <= load_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      idx_q     <= idx_d;
      refresh_q <= refresh_d;
    end
  end

  logic [19:0] bcd;
  logic [1:0]  sel;

  always_comb begin
    bcd = to_bcd(product_q);
    sel = refresh_q[REFRESH_BITS-1 -: 2];
    case (sel)
      2'd0: begin anodes = 4'b1110; segments = seg7(pick(bcd, {1'b0, idx_q})); end
      2'd1: begin anodes = 4'b1101; segments = seg7(pick(bcd, {1'b0, idx_q} + 3'd1)); end
      2'd2: begin anodes = 4'b1011; segments = seg7(pick(bcd, {1'b0, idx_q} + 3'd2)); end
      default: begin
        anodes   = 4'b0111;
        segments = (sign_q && product_q != '0) ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  assign done = done_q;
  assign load = load_q;
  assign en   = en_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - directed self-checking bench for the multiplier board block
module tb_main;

  localparam int DB = 16;
  localparam int RB = 4;
  localparam int RP = 1 << RB;

  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] SM = 7'h3F;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S6 = 7'h02;
  localparam logic [6:0] S8 = 7'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] num1, num2;
  logic       start_btn, rst_btn, shift_right_btn, shift_left_btn;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic       done, sh_right_led, sh_left_led, rst_led, start_led, load, dir, en;

  int total = 0;
  int bad   = 0;

  main #(.DEBOUNCE_CYCLES(DB), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2),
    .start_btn(start_btn), .rst_btn(rst_btn),
    .shift_right_btn(shift_right_btn), .shift_left_btn(shift_left_btn),
    .segments(segments), .anodes(anodes), .done(done),
    .sh_right_led(sh_right_led), .sh_left_led(sh_left_led),
    .rst_led(rst_led), .start_led(start_led),
    .load(load), .dir(dir), .en(en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Capture one full refresh period and compare each digit position.
  task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] s3, s2, s1, s0;
    int odd;
    s3 = 'x; s2 = 'x; s1 = 'x; s0 = 'x;
    odd = 0;
    repeat (RP) begin
      @(negedge clk);
      case (anodes)
        4'b1110: s0 = segments;
        4'b1101: s1 = segments;
        4'b1011: s2 = segments;
        4'b0111: s3 = segments;
        default: odd++;
      endcase
    end
    chk({tag, "_anodes"}, odd, 0);
    chk({tag, "_dig3"}, {25'd0, s3}, {25'd0, e3});
    chk({tag, "_dig2"}, {25'd0, s2}, {25'd0, e2});
    chk({tag, "_dig1"}, {25'd0, s1}, {25'd0, e1});
    chk({tag, "_dig0"}, {25'd0, s0}, {25'd0, e0});
  endtask

  task automatic press_scroll(input string tag, input bit left);
    if (left) shift_left_btn = 1'b1; else shift_right_btn = 1'b1;
    cycles(DB + 6);
    chk({tag, "_led"}, left ? sh_left_led : sh_right_led, 1);
    shift_left_btn  = 1'b0;
    shift_right_btn = 1'b0;
    cycles(DB + 6);
    chk({tag, "_dir"}, dir, left);
  endtask

  task automatic run_mult(input string tag, input logic [7:0] a, input logic [7:0] b);
    int k, n, en_cnt, ld_cnt;
    num1 = a;
    num2 = b;
    start_btn = 1'b1;
    k = 0;
    while (load !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_load"}, load, 1);
    chk({tag, "_start_led"}, start_led, 1);
    n = 0; en_cnt = 0; ld_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (en === 1'b1) en_cnt++;
      if (load === 1'b1) ld_cnt++;
      // Operands are already captured; later switch changes must not matter.
      if (n == 1) begin num1 = 8'h7F; num2 = 8'h7F; end
    end while (done !== 1'b1 && n < 20);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_en_cycles"}, en_cnt, 8);
    chk({tag, "_load_width"}, ld_cnt, 0);
    start_btn = 1'b0;
    cycles(DB + 6);
    chk({tag, "_done_held"}, done, 1);
  endtask

  initial begin
    int k, ld_cnt, led_cnt;
    rst_n = 1'b0;
    num1 = 8'd0; num2 = 8'd0;
    start_btn = 1'b0; rst_btn = 1'b0; shift_right_btn = 1'b0; shift_left_btn = 1'b0;
    cycles(3);
    chk("rst_done", done, 0);
    chk("rst_load", load, 0);
    chk("rst_en", en, 0);
    chk("rst_dir", dir, 0);
    chk("rst_leds", {sh_right_led, sh_left_led, rst_led, start_led}, 0);
    chk("rst_anodes", anodes, 4'b1110);
    rst_n = 1'b1;
    check_disp("rst_disp", SB, S0, S0, S0);

    run_mult("m5x10", 8'd5, 8'd10);
    check_disp("m5x10_disp", SB, S0, S5, S0);

    press_scroll("r0", 1'b0);
    check_disp("r0_disp", SB, S0, S5, S0);
    press_scroll("l1", 1'b1);
    check_disp("l1_disp", SB, S0, S0, S5);
    press_scroll("l2", 1'b1);
    check_disp("l2_disp", SB, S0, S0, S0);
    press_scroll("l3", 1'b1);
    check_disp("l3_disp", SB, S0, S0, S0);
    press_scroll("r1", 1'b0);
    press_scroll("r2", 1'b0);

    run_mult("mneg", 8'hFD, 8'd5);
    check_disp("mneg_disp", SM, S0, S1, S5);

    run_mult("m128", 8'h80, 8'h80);
    check_disp("m128_i0", SB, S3, S8, S4);
    press_scroll("m128_l1", 1'b1);
    press_scroll("m128_l2", 1'b1);
    check_disp("m128_i2", SB, S1, S6, S3);

    // Clear lands 5 cycles after the start pulse, inside RUN.
    num1 = 8'd7; num2 = 8'd9;
    start_btn = 1'b1;
    cycles(5);
    rst_btn = 1'b1;
    k = 0;
    while (rst_led !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("clr_rst_led", rst_led, 1);
    chk("clr_en_before", en, 1);
    cycles(1);
    chk("clr_en_after", en, 0);
    chk("clr_done_after", done, 0);
    cycles(15);
    chk("clr_done_stays", done, 0);
    chk("clr_rst_led_held", rst_led, 1);
    check_disp("clr_disp", SB, S0, S0, S0);
    start_btn = 1'b0;
    rst_btn = 1'b0;
    cycles(DB + 6);

    // A start glitch shorter than the debounce window must be ignored.
    start_btn = 1'b1;
    cycles(DB / 2);
    start_btn = 1'b0;
    ld_cnt = 0; led_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (load === 1'b1) ld_cnt++;
      if (start_led === 1'b1) led_cnt++;
    end
    chk("glitch_load", ld_cnt, 0);
    chk("glitch_led", led_cnt, 0);
    chk("glitch_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
